// File: rtl/seg7_scan_driver.sv
// Four-digit hex scanner for a common-anode multiplexed 7-segment display.
// Captures into a pending register, commits at frame wrap, and blanks between digits.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        lz_en,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    typedef enum logic {BLANK, SHOW} state_t;

    state_t        state, state_n;
    logic [1:0]    idx, idx_n;
    logic [BW-1:0] blank_cnt, blank_cnt_n;
    logic [PW-1:0] presc;
    logic          tick;
    logic [15:0]   pending, disp;
    logic [15:0]   shifted;
    logic          suppress;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign tick = (presc == PW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) presc <= '0;
        else       presc <= tick ? '0 : presc + 1'b1;
    end

    // A load on the wrap edge bypasses pending so it lands in this frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            disp    <= '0;
        end else begin
            if (load) pending <= value;
            if (tick && idx == 2'd3) disp <= load ? value : pending;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= (BLANK_CYCLES > 0) ? BLANK : SHOW;
            idx       <= '0;
            blank_cnt <= BW'(BLANK_CYCLES);
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            blank_cnt <= blank_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        blank_cnt_n = blank_cnt;
        if (tick) begin
            idx_n = idx + 2'd1;
            if (BLANK_CYCLES > 0) begin
                state_n     = BLANK;
                blank_cnt_n = BW'(BLANK_CYCLES);
            end else begin
                state_n = SHOW;
            end
        end else if (state == BLANK) begin
            if (blank_cnt != '0) blank_cnt_n = blank_cnt - 1'b1;
            if (blank_cnt <= BW'(1)) state_n = SHOW;
        end
    end

    // A digit is a leading zero when it and every higher nibble are zero.
    assign shifted  = disp >> {idx, 2'b00};
    assign suppress = lz_en && (idx != 2'd0) && (shifted == 16'h0000);

    always_comb begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state == SHOW) begin
            an_d  = ~(4'b0001 << idx);
            seg_d = suppress ? 7'h7F : hex7(shifted[3:0]);
            dp_d  = ~dp_in[idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: one instance with blanking, one without,
// driven from the same inputs and checked sample-by-sample over whole frames.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        lz_en;
    logic [3:0]  dp_in;
    logic [3:0]  an, an2;
    logic [6:0]  seg, seg2;
    logic        dp, dp2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load), .lz_en(lz_en),
        .dp_in(dp_in), .an(an), .seg(seg), .dp(dp)
    );

    seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(0)) dut_nb (
        .clk(clk), .reset(reset), .value(value), .load(load), .lz_en(lz_en),
        .dp_in(dp_in), .an(an2), .seg(seg2), .dp(dp2)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Entered on the negedge that follows a frame boundary (0 edges into the frame).
    // Optional loads are driven before edge ld_a+1 / ld_b+1 of the frame.
    task automatic check_frame(input string name,
                               input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3,
                               input int ld_a, input logic [15:0] va,
                               input int ld_b, input logic [15:0] vb);
        logic [6:0] e [4];
        logic [3:0] an_exp;
        int         k;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int s = 0; s < 4; s++) begin
            an_exp = ~(4'b0001 << s);
            for (int c = 0; c < 8; c++) begin
                k = s * 8 + c;
                if (k == ld_a) begin
                    load = 1'b1; value = va;
                end else if (k == ld_b) begin
                    load = 1'b1; value = vb;
                end else begin
                    load = 1'b0;
                end
                @(negedge clk);
                if (c < 2) begin
                    check($sformatf("%s s%0d c%0d an", name, s, c), {12'h0, an}, 16'h000F);
                    check($sformatf("%s s%0d c%0d seg", name, s, c), {9'h0, seg}, 16'h007F);
                    check($sformatf("%s s%0d c%0d dp", name, s, c), {15'h0, dp}, 16'h0001);
                end else begin
                    check($sformatf("%s s%0d c%0d an", name, s, c), {12'h0, an}, {12'h0, an_exp});
                    check($sformatf("%s s%0d c%0d seg", name, s, c), {9'h0, seg}, {9'h0, e[s]});
                    check($sformatf("%s s%0d c%0d dp", name, s, c), {15'h0, dp}, {15'h0, ~dp_in[s]});
                end
                check($sformatf("%s nb s%0d c%0d an", name, s, c), {12'h0, an2}, {12'h0, an_exp});
                check($sformatf("%s nb s%0d c%0d seg", name, s, c), {9'h0, seg2}, {9'h0, e[s]});
            end
        end
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        value = 16'h0000;
        load  = 1'b0;
        lz_en = 1'b0;
        dp_in = 4'b0000;
        repeat (2) @(negedge clk);
        check("rst an", {12'h0, an}, 16'h000F);
        check("rst seg", {9'h0, seg}, 16'h007F);
        check("rst dp", {15'h0, dp}, 16'h0001);
        check("rst nb an", {12'h0, an2}, 16'h000F);
        reset = 1'b0;

        @(negedge clk);
        check("boot blank1 an", {12'h0, an}, 16'h000F);
        check("boot nb an1", {12'h0, an2}, 16'h000E);
        @(negedge clk);
        check("boot blank2 an", {12'h0, an}, 16'h000F);
        @(negedge clk);
        check("boot d0 an", {12'h0, an}, 16'h000E);
        check("boot d0 seg", {9'h0, seg}, 16'h0040);
        @(negedge clk);
        check("boot d0 hold an", {12'h0, an}, 16'h000E);

        // Asynchronous reset in the middle of a SHOW slot.
        #2 reset = 1'b1;
        #1;
        check("async rst an", {12'h0, an}, 16'h000F);
        check("async rst seg", {9'h0, seg}, 16'h007F);
        check("async rst dp", {15'h0, dp}, 16'h0001);
        check("async rst nb an", {12'h0, an2}, 16'h000F);
        @(negedge clk);
        reset = 1'b0;

        check_frame("A",  7'h40, 7'h40, 7'h40, 7'h40,  0, 16'h12AF, -1, 16'h0);
        check_frame("B",  7'h0E, 7'h08, 7'h24, 7'h79,  5, 16'h0005, -1, 16'h0);
        lz_en = 1'b1;
        check_frame("C",  7'h12, 7'h7F, 7'h7F, 7'h7F, -1, 16'h0,    -1, 16'h0);
        lz_en = 1'b0;
        check_frame("D",  7'h12, 7'h40, 7'h40, 7'h40,  0, 16'h0000, -1, 16'h0);
        lz_en = 1'b1;
        check_frame("E",  7'h40, 7'h7F, 7'h7F, 7'h7F, 31, 16'hBEEF, -1, 16'h0);
        check_frame("F",  7'h0E, 7'h06, 7'h06, 7'h03,  3, 16'h1111, 20, 16'h2222);
        dp_in = 4'b0100;
        check_frame("G",  7'h24, 7'h24, 7'h24, 7'h24, -1, 16'h0,    -1, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
